// File: rtl/alu_wb_pkg.sv
// Shared definitions for the ALU writeback sequencer.
//   - wr_target encodings driven onto the register write port
//   - sequencer FSM state type
//   - FIFO entry layout {result, wide, dest} and a helper giving its width
package alu_wb_pkg;

  localparam logic [1:0] WT_GPR = 2'b00;
  localparam logic [1:0] WT_LO  = 2'b01;
  localparam logic [1:0] WT_HI  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GPR  = 2'd1,
    ST_LO   = 2'd2,
    ST_HI   = 2'd3
  } wb_state_e;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_REG_IDX_W = 4;

  // Entry layout at the default widths. The FIFO carries the same fields
  // packed MSB-first as a flat vector so that other widths also work.
  typedef struct packed {
    logic [2*DEF_DATA_W-1:0]  result;
    logic                     wide;
    logic [DEF_REG_IDX_W-1:0] dest;
  } wb_entry_t;

  function automatic int entry_width(input int data_w, input int reg_idx_w);
    return 2 * data_w + 1 + reg_idx_w;
  endfunction

endpackage

// File: rtl/alu_writeback_sequencer_result_fifo.sv
// result_fifo: 2-entry synchronous FIFO with registered occupancy.
// Ports:
//   clock, clear_n     clock / asynchronous active-low reset
//   push, push_data    write an entry (ignored when full)
//   pop                drop the head entry (ignored when empty)
//   full, empty        decoded from the registered occupancy
//   head               current head entry (first-word fall-through)
module result_fifo #(
  parameter int ENTRY_W = 69
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [ENTRY_W-1:0] head
);

  logic [ENTRY_W-1:0] mem_q [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               push_ok, pop_ok;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = ~wr_ptr_q;
    if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/alu_writeback_sequencer.sv
// alu_writeback_sequencer: buffers up to two 64-bit ALU results and
// sequences them onto one 32-bit register write port. Narrow results give
// one GPR write; wide (MUL/DIV) results give a LO write then a HI write.
// Ports:
//   clock, clear_n                  clock / asynchronous active-low reset
//   in_valid/in_ready               input handshake
//   in_result, in_wide, in_dest     ALU result, two-write flag, GPR index
//   wr_valid/wr_ready               register write handshake
//   wr_target, wr_addr, wr_data     write target (GPR/LO/HI), index, data
//   busy                            buffered entry or write in flight
//   op_count                        operations fully written (wraps)
module alu_writeback_sequencer
  import alu_wb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DATA_W-1:0]   in_result,
  input  logic                  in_wide,
  input  logic [REG_IDX_W-1:0]  in_dest,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [1:0]            wr_target,
  output logic [REG_IDX_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  busy,
  output logic [CNT_W-1:0]      op_count
);

  localparam int ENTRY_W = entry_width(DATA_W, REG_IDX_W);

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]   fifo_head;
  logic [2*DATA_W-1:0]  head_result;
  logic                 head_wide;
  logic [REG_IDX_W-1:0] head_dest;

  wb_state_e            state_q, state_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [1:0]           wr_target_q, wr_target_d;
  logic [REG_IDX_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic [DATA_W-1:0]    hi_data_q, hi_data_d;
  logic [CNT_W-1:0]     op_count_q, op_count_d;
  logic                 wr_accept, load_next;

  assign fifo_push = in_valid && in_ready;

  result_fifo #(.ENTRY_W(ENTRY_W)) u_fifo (
    .clock     (clock),
    .clear_n   (clear_n),
    .push      (fifo_push),
    .push_data ({in_result, in_wide, in_dest}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign head_result = fifo_head[ENTRY_W-1 -: 2*DATA_W];
  assign head_wide   = fifo_head[REG_IDX_W];
  assign head_dest   = fifo_head[REG_IDX_W-1:0];

  assign in_ready  = !fifo_full;
  assign wr_accept = wr_valid_q && wr_ready;

  always_comb begin
    state_d     = state_q;
    wr_valid_d  = wr_valid_q;
    wr_target_d = wr_target_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    hi_data_d   = hi_data_q;
    op_count_d  = op_count_q;
    fifo_pop    = 1'b0;
    load_next   = 1'b0;

    case (state_q)
      ST_IDLE: load_next = !fifo_empty;
      ST_GPR, ST_HI: begin
        if (wr_accept) begin
          op_count_d = op_count_q + CNT_W'(1);
          // Chain straight into the next buffered operation so there is no
          // idle bubble between back-to-back results.
          if (!fifo_empty) begin
            load_next = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            wr_valid_d = 1'b0;
          end
        end
      end
      ST_LO: begin
        if (wr_accept) begin
          state_d     = ST_HI;
          wr_target_d = WT_HI;
          wr_data_d   = hi_data_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_next) begin
      fifo_pop   = 1'b1;
      wr_valid_d = 1'b1;
      wr_data_d  = head_result[DATA_W-1:0];
      if (head_wide) begin
        state_d     = ST_LO;
        wr_target_d = WT_LO;
        wr_addr_d   = '0;
        // Upper half waits here until the LO write is accepted.
        hi_data_d   = head_result[2*DATA_W-1:DATA_W];
      end else begin
        state_d     = ST_GPR;
        wr_target_d = WT_GPR;
        wr_addr_d   = head_dest;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= ST_IDLE;
      wr_valid_q  <= 1'b0;
      wr_target_q <= WT_GPR;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      hi_data_q   <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_valid_q  <= wr_valid_d;
      wr_target_q <= wr_target_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      hi_data_q   <= hi_data_d;
      op_count_q  <= op_count_d;
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_target = wr_target_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign op_count  = op_count_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule
